// File: rtl/idt_pll_config_ctrl.sv
// Serial programming sequencer for the IDT pixel-clock synthesizer: shifts a
// 24-bit config word out MSB-first, pulses the load strobe, then waits for PLL lock.
module idt_pll_config_ctrl #(
    parameter int          CLK_DIV     = 4,
    parameter int          LOCK_WAIT   = 1000000,
    parameter logic [23:0] BOOT_CONFIG = 24'h31149F
) (
    input  logic        osc_clk,
    input  logic        osc_reset_,
    input  logic        cfg_req,
    input  logic [23:0] cfg_word,
    output logic        cfg_ack,
    output logic        busy,
    output logic        locked,
    output logic [23:0] cfg_current,
    output logic        idt_sclk,
    output logic        idt_data,
    output logic        idt_strobe
);
    localparam int PW = $clog2(2 * CLK_DIV + 1);
    localparam int SW = $clog2(LOCK_WAIT + 1);
    localparam logic [PW-1:0] HALF_LOAD   = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] STRB_LOAD   = PW'(2 * CLK_DIV - 1);
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(LOCK_WAIT - 1);

    typedef enum logic [2:0] {BOOT, IDLE, SHIFT_LO, SHIFT_HI, STROBE, SETTLE} state_t;

    state_t        state, state_n;
    logic [4:0]    bit_idx, bit_idx_n;
    logic [PW-1:0] phase_cnt, phase_cnt_n;
    logic [SW-1:0] settle_cnt, settle_cnt_n;
    logic [23:0]   shreg, shreg_n;
    logic [23:0]   cfg_current_n;
    logic          cfg_ack_n, busy_n, locked_n, sclk_n, data_n, strobe_n;

    always_ff @(posedge osc_clk or negedge osc_reset_) begin
        if (!osc_reset_) begin
            state       <= BOOT;
            bit_idx     <= '0;
            phase_cnt   <= '0;
            settle_cnt  <= '0;
            shreg       <= BOOT_CONFIG;
            cfg_current <= '0;
            cfg_ack     <= 1'b0;
            busy        <= 1'b0;
            locked      <= 1'b0;
            idt_sclk    <= 1'b0;
            idt_data    <= 1'b0;
            idt_strobe  <= 1'b0;
        end else begin
            state       <= state_n;
            bit_idx     <= bit_idx_n;
            phase_cnt   <= phase_cnt_n;
            settle_cnt  <= settle_cnt_n;
            shreg       <= shreg_n;
            cfg_current <= cfg_current_n;
            cfg_ack     <= cfg_ack_n;
            busy        <= busy_n;
            locked      <= locked_n;
            idt_sclk    <= sclk_n;
            idt_data    <= data_n;
            idt_strobe  <= strobe_n;
        end
    end

    always_comb begin
        state_n       = state;
        bit_idx_n     = bit_idx;
        phase_cnt_n   = phase_cnt;
        settle_cnt_n  = settle_cnt;
        shreg_n       = shreg;
        cfg_current_n = cfg_current;
        cfg_ack_n     = 1'b0;
        busy_n        = busy;
        locked_n      = locked;
        sclk_n        = idt_sclk;
        data_n        = idt_data;
        strobe_n      = idt_strobe;

        case (state)
            BOOT: begin
                state_n       = SHIFT_LO;
                bit_idx_n     = 5'd23;
                phase_cnt_n   = HALF_LOAD;
                shreg_n       = BOOT_CONFIG;
                cfg_current_n = BOOT_CONFIG;
                busy_n        = 1'b1;
                locked_n      = 1'b0;
                sclk_n        = 1'b0;
                data_n        = BOOT_CONFIG[23];
                strobe_n      = 1'b0;
            end
            IDLE: begin
                if (cfg_req) begin
                    state_n       = SHIFT_LO;
                    bit_idx_n     = 5'd23;
                    phase_cnt_n   = HALF_LOAD;
                    shreg_n       = cfg_word;
                    cfg_current_n = cfg_word;
                    cfg_ack_n     = 1'b1;
                    busy_n        = 1'b1;
                    locked_n      = 1'b0;
                    sclk_n        = 1'b0;
                    data_n        = cfg_word[23];
                end
            end
            SHIFT_LO: begin
                if (phase_cnt == '0) begin
                    state_n     = SHIFT_HI;
                    phase_cnt_n = HALF_LOAD;
                    sclk_n      = 1'b1;
                end else begin
                    phase_cnt_n = phase_cnt - PW'(1);
                end
            end
            SHIFT_HI: begin
                if (phase_cnt != '0) begin
                    phase_cnt_n = phase_cnt - PW'(1);
                end else if (bit_idx != 5'd0) begin
                    // Next bit moves into the MSB so idt_data always drives shreg[23].
                    state_n     = SHIFT_LO;
                    bit_idx_n   = bit_idx - 5'd1;
                    phase_cnt_n = HALF_LOAD;
                    shreg_n     = {shreg[22:0], 1'b0};
                    sclk_n      = 1'b0;
                    data_n      = shreg[22];
                end else begin
                    state_n     = STROBE;
                    phase_cnt_n = STRB_LOAD;
                    sclk_n      = 1'b0;
                    data_n      = 1'b0;
                    strobe_n    = 1'b1;
                end
            end
            STROBE: begin
                if (phase_cnt == '0) begin
                    state_n      = SETTLE;
                    settle_cnt_n = SETTLE_LOAD;
                    strobe_n     = 1'b0;
                end else begin
                    phase_cnt_n = phase_cnt - PW'(1);
                end
            end
            SETTLE: begin
                if (settle_cnt == '0) begin
                    state_n  = IDLE;
                    busy_n   = 1'b0;
                    locked_n = 1'b1;
                end else begin
                    settle_cnt_n = settle_cnt - SW'(1);
                end
            end
            default: state_n = BOOT;
        endcase
    end
endmodule

// File: tb/tb_idt_pll_config_ctrl.sv
// Self-checking bench for idt_pll_config_ctrl: serial words are captured from the
// pins and checked against a scoreboard queue; latencies checked against the timing model.
module tb_idt_pll_config_ctrl;
  localparam int          CLK_DIV    = 2;
  localparam int          LOCK_WAIT  = 16;
  localparam int          CLK_DIV1   = 1;
  localparam int          LOCK_WAIT1 = 1;
  localparam logic [23:0] BOOT       = 24'h31149F;
  localparam int          LAT0       = 48 * CLK_DIV + 2 * CLK_DIV + LOCK_WAIT;
  localparam int          LAT1       = 48 * CLK_DIV1 + 2 * CLK_DIV1 + LOCK_WAIT1;

  // clock / reset
  logic osc_clk = 1'b0;
  always #5 osc_clk = ~osc_clk;

  logic        osc_reset_, cfg_req;
  logic [23:0] cfg_word;
  logic        cfg_ack, busy, locked, idt_sclk, idt_data, idt_strobe;
  logic [23:0] cfg_current;

  logic        rst1_, req1;
  logic [23:0] word1;
  logic        ack1, busy1, locked1, sclk1, data1, strobe1;
  logic [23:0] cur1;

  idt_pll_config_ctrl #(.CLK_DIV(CLK_DIV), .LOCK_WAIT(LOCK_WAIT), .BOOT_CONFIG(BOOT)) dut (
    .osc_clk(osc_clk), .osc_reset_(osc_reset_), .cfg_req(cfg_req), .cfg_word(cfg_word),
    .cfg_ack(cfg_ack), .busy(busy), .locked(locked), .cfg_current(cfg_current),
    .idt_sclk(idt_sclk), .idt_data(idt_data), .idt_strobe(idt_strobe)
  );

  idt_pll_config_ctrl #(.CLK_DIV(CLK_DIV1), .LOCK_WAIT(LOCK_WAIT1), .BOOT_CONFIG(BOOT)) dut1 (
    .osc_clk(osc_clk), .osc_reset_(rst1_), .cfg_req(req1), .cfg_word(word1),
    .cfg_ack(ack1), .busy(busy1), .locked(locked1), .cfg_current(cur1),
    .idt_sclk(sclk1), .idt_data(data1), .idt_strobe(strobe1)
  );

  // observed instance select
  logic sel;
  logic m_rst, m_ack, m_busy, m_locked, m_sclk, m_data, m_strobe;
  logic [23:0] m_cur;
  assign m_rst    = sel ? rst1_   : osc_reset_;
  assign m_ack    = sel ? ack1    : cfg_ack;
  assign m_busy   = sel ? busy1   : busy;
  assign m_locked = sel ? locked1 : locked;
  assign m_sclk   = sel ? sclk1   : idt_sclk;
  assign m_data   = sel ? data1   : idt_data;
  assign m_strobe = sel ? strobe1 : idt_strobe;
  assign m_cur    = sel ? cur1    : cfg_current;

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: capture bits on sclk rising edges, compare at strobe rise
  int          bit_cnt;
  logic [23:0] cap;
  logic        prev_sclk, prev_data, prev_strobe;
  always @(negedge osc_clk) begin
    if (!m_rst) begin
      bit_cnt = 0; cap = '0; prev_sclk = 0; prev_data = 0; prev_strobe = 0;
    end else begin
      if (m_sclk && !prev_sclk) begin
        cap = {cap[22:0], m_data};
        bit_cnt++;
      end
      if (m_sclk && prev_sclk) chk_eq("data_stable_sclk_high", m_data, prev_data);
      if (m_strobe && !prev_strobe) begin
        chk_eq("bits_per_word", bit_cnt, 24);
        chk_eq("exp_q_nonempty", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk_eq("captured_word", cap, exp_q.pop_front());
        bit_cnt = 0;
      end
      if (m_strobe) chk_eq("sclk_low_in_strobe", m_sclk, 0);
      chk_eq("busy_and_locked", m_busy & m_locked, 0);
      prev_sclk = m_sclk; prev_data = m_data; prev_strobe = m_strobe;
    end
  end

  // driver: step edges until locked, recording ack/strobe timing
  task automatic run_seq(input int budget, output int lock_n, output int ack_n,
                         output int acks, output int strb);
    lock_n = -1; ack_n = -1; acks = 0; strb = 0;
    for (int n = 1; n <= budget; n++) begin
      @(posedge osc_clk); #1;
      if (m_ack) begin
        acks++;
        if (ack_n < 0) ack_n = n;
        chk_eq("locked_low_at_ack", m_locked, 0);
        cfg_req = 0; req1 = 0;
        cfg_word = ~cfg_word; word1 = ~word1;
      end
      if (m_strobe) strb++;
      if (m_locked) begin
        lock_n = n;
        break;
      end
    end
    chk_eq("locked_within_budget", lock_n > 0, 1);
  endtask

  typedef struct {
    logic [23:0] word;
    int          exp_lat;
  } vec_t;
  vec_t vecs[5];

  int lock_n, ack_n, acks, strb;

  initial begin
    vecs[0] = '{24'hA5A5A5, LAT0};
    vecs[1] = '{24'h000000, LAT0};
    vecs[2] = '{24'hFFFFFF, LAT0};
    vecs[3] = '{24'h800001, LAT0};
    vecs[4] = '{24'($urandom_range(0, 24'hFFFFFF)), LAT0};

    sel = 0;
    osc_reset_ = 0; cfg_req = 0; cfg_word = '0;
    rst1_ = 0; req1 = 0; word1 = '0;
    repeat (3) @(negedge osc_clk);
    chk_eq("reset_outputs_zero",
           {cfg_ack, busy, locked, cfg_current, idt_sclk, idt_data, idt_strobe}, 0);

    // boot sequence
    osc_reset_ = 1;
    exp_q.push_back(BOOT);
    run_seq(400, lock_n, ack_n, acks, strb);
    chk_eq("boot_lock_cycle", lock_n, 1 + LAT0);
    chk_eq("boot_no_ack", acks, 0);
    chk_eq("boot_strobe_len", strb, 2 * CLK_DIV);
    chk_eq("boot_cfg_current", cfg_current, BOOT);

    // runtime requests from the table
    for (int i = 0; i < 5; i++) begin
      @(posedge osc_clk); #1;
      cfg_req = 1; cfg_word = vecs[i].word;
      exp_q.push_back(vecs[i].word);
      run_seq(400, lock_n, ack_n, acks, strb);
      chk_eq("rt_ack_first_edge", ack_n, 1);
      chk_eq("rt_ack_count", acks, 1);
      chk_eq("rt_lock_latency", lock_n - ack_n, vecs[i].exp_lat);
      chk_eq("rt_cfg_current", cfg_current, vecs[i].word);
    end

    // request held through boot
    @(posedge osc_clk); #1;
    osc_reset_ = 0; cfg_req = 1; cfg_word = 24'h000001;
    exp_q.delete();
    repeat (3) @(negedge osc_clk);
    osc_reset_ = 1;
    exp_q.push_back(BOOT);
    exp_q.push_back(24'h000001);
    run_seq(400, lock_n, ack_n, acks, strb);
    chk_eq("held_boot_lock_cycle", lock_n, 1 + LAT0);
    chk_eq("held_no_ack_while_busy", acks, 0);
    run_seq(400, lock_n, ack_n, acks, strb);
    chk_eq("held_ack_after_idle", ack_n, 1);
    chk_eq("held_ack_count", acks, 1);
    chk_eq("held_lock_latency", lock_n - ack_n, LAT0);
    chk_eq("held_cfg_current", cfg_current, 24'h000001);

    // reset during bit 10 of a runtime word
    @(posedge osc_clk); #1;
    cfg_req = 1; cfg_word = 24'h123456;
    exp_q.push_back(24'h123456);
    @(posedge osc_clk); #1;
    chk_eq("midrst_ack", cfg_ack, 1);
    cfg_req = 0;
    repeat (2 * CLK_DIV * 13 + 1) @(posedge osc_clk);
    #3;
    chk_eq("midrst_busy_before", busy, 1);
    chk_eq("midrst_bits_before", bit_cnt, 13);
    osc_reset_ = 0;
    #1;
    chk_eq("midrst_outputs_zero",
           {cfg_ack, busy, locked, cfg_current, idt_sclk, idt_data, idt_strobe}, 0);
    exp_q.delete();
    repeat (3) @(negedge osc_clk);
    osc_reset_ = 1;
    exp_q.push_back(BOOT);
    run_seq(400, lock_n, ack_n, acks, strb);
    chk_eq("midrst_reboot_lock", lock_n, 1 + LAT0);
    chk_eq("midrst_reboot_current", cfg_current, BOOT);

    // CLK_DIV=1, LOCK_WAIT=1 instance
    @(negedge osc_clk);
    sel = 1;
    @(negedge osc_clk);
    rst1_ = 1;
    exp_q.push_back(BOOT);
    run_seq(200, lock_n, ack_n, acks, strb);
    chk_eq("fast_boot_lock", lock_n, 1 + LAT1);
    chk_eq("fast_strobe_len", strb, 2 * CLK_DIV1);
    chk_eq("fast_no_ack", acks, 0);
    @(posedge osc_clk); #1;
    req1 = 1; word1 = 24'h5A0FF0;
    exp_q.push_back(24'h5A0FF0);
    run_seq(200, lock_n, ack_n, acks, strb);
    chk_eq("fast_rt_ack", ack_n, 1);
    chk_eq("fast_rt_lock_latency", lock_n - ack_n, LAT1);
    chk_eq("fast_rt_current", cur1, 24'h5A0FF0);

    @(negedge osc_clk);
    chk_eq("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
